// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, frame constants
// and the odd-parity check used at the stop bit.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // START_OK is folded into DATA with bit count 0
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data_byte,
                                         input logic                     parity);
    return ^data_byte ^ parity;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty/valid already mask stale
  // contents, and a reset here would stop the array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit device-to-host
// frames, checks start/parity/stop and queues good scan codes in a FWFT FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          ready,
  output logic [PS2_DATA_BITS-1:0]      data,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int                 TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]               clk_sync;
  logic [2:0]               data_sync;
  logic                     fe;
  logic                     bit_in;

  ps2_state_e               state, state_d;
  logic [2:0]               bit_cnt, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_reg, shift_d;
  logic                     parity_bit, parity_d;
  logic [TO_W-1:0]          to_cnt, to_cnt_d;
  logic                     frame_err_d;
  logic                     overflow_d;

  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [PS2_DATA_BITS-1:0] fifo_head;

  // Idle-high line levels at reset, so release never fabricates a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  assign fe     = (clk_sync[2:1] == 2'b10);
  assign bit_in = data_sync[2];

  assign valid = !fifo_empty;
  assign pop   = valid && ready;
  assign data  = valid ? fifo_head : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      shift_reg  <= shift_d;
      parity_bit <= parity_d;
      to_cnt     <= to_cnt_d;
      frame_err  <= frame_err_d;
      overflow   <= overflow_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shift_d     = shift_reg;
    parity_d    = parity_bit;
    to_cnt_d    = to_cnt + 1'b1;
    frame_err_d = 1'b0;
    overflow_d  = overflow;
    push        = 1'b0;

    if (state == ST_IDLE || fe) to_cnt_d = '0;

    // A stalled device aborts the frame even if an edge arrives in the same cycle.
    if (state != ST_IDLE && to_cnt == TO_LAST) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else if (fe) begin
      unique case (state)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_in, shift_reg[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = bit_in;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_in && odd_parity_ok(shift_reg, parity_bit)) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   overflow_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  ps2_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_reg),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule
